// File: rtl/serial_shift_unit_if.sv
// Request/result bundle between the control FSM (master) and the serial shift unit (slave).
interface serial_shift_unit_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               start;
    logic [2:0]         op;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   data_in;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   data_out;

    modport master (
        output start, op, shamt, data_in,
        input  busy, done, data_out
    );

    modport slave (
        input  start, op, shamt, data_in,
        output busy, done, data_out
    );
endinterface

// File: rtl/serial_shift_unit.sv
// One-bit-per-clock shift/rotate unit; result is published on entry to DONE and
// held until the next accepted request completes.
module serial_shift_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_shift_unit_if.slave   bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   data_out_q, data_out_d;
    logic [WIDTH-1:0]   step;
    logic               accept;
    logic               trivial;

    always_comb begin
        step = shreg_q;
        case (op_q)
            OP_SLL:  step = {shreg_q[WIDTH-2:0], 1'b0};
            OP_SRL:  step = {1'b0, shreg_q[WIDTH-1:1]};
            OP_SRA:  step = {shreg_q[WIDTH-1], shreg_q[WIDTH-1:1]};
            OP_ROL:  step = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
            OP_ROR:  step = {shreg_q[0], shreg_q[WIDTH-1:1]};
            default: step = shreg_q;
        endcase
    end

    // Requests arriving while shifting are dropped, not queued.
    assign accept  = bus.start && (state_q != ST_SHIFT);
    assign trivial = (bus.shamt == '0) || (bus.op > OP_ROR);

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        data_out_d = data_out_q;
        if (accept) begin
            op_d    = bus.op;
            shreg_d = bus.data_in;
            if (trivial) begin
                state_d    = ST_DONE;
                cnt_d      = '0;
                data_out_d = bus.data_in;
            end else begin
                state_d = ST_SHIFT;
                cnt_d   = bus.shamt;
            end
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    shreg_d = step;
                    cnt_d   = cnt_q - 1'b1;
                    if (cnt_q == SHAMT_W'(1)) begin
                        state_d    = ST_DONE;
                        data_out_d = step;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            op_q       <= '0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            data_out_q <= data_out_d;
        end
    end

    assign bus.busy     = (state_q == ST_SHIFT);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.data_out = data_out_q;
endmodule

// File: doc/serial_shift_unit.md
Name: serial_shift_unit

Overview:
- Multi-cycle shift unit directly downstream of the SLLSrcA operand mux.
- Consumes the selected 32-bit operand (A, immediate or B) and produces the shift/rotate result for the register-file write-back path.
- Shifts one bit per clock under a start/busy/done handshake driven by the control FSM.
- The result is held stable until the next accepted start.

Parameters:
WIDTH, 32, data width of operand and result
SHAMT_W, 5, width of shift amount (max shift WIDTH-1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request; sampled on rising edge when unit not busy
op  input  3  operation: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 pass-through
shamt  input  SHAMT_W  shift amount
data_in  input  WIDTH  operand from SLLSrcA mux
busy  output  1  high while a shift is in progress
done  output  1  one-cycle pulse: data_out holds new result
data_out  output  WIDTH  result register

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, busy=0, done=0, data_out=0, internal shift register and counter=0. Reset asserted mid-operation aborts the shift; no done pulse is produced.
- States:
  - IDLE: waiting for start.
  - SHIFT: shifting one bit per edge.
  - DONE: done asserted for exactly one cycle.
- Acceptance:
  - start=1 at a rising edge E0 while in IDLE or DONE latches data_in, op and shamt into internal registers.
  - The latched values are used for the whole operation; later input changes are ignored.
- Transitions:
  - IDLE/DONE with start and shamt>0 and op valid -> SHIFT, counter=shamt.
  - IDLE/DONE with start and (shamt=0 or op in 101-111) -> DONE directly, result=data_in unchanged.
  - SHIFT: each edge applies one 1-bit step and decrements counter. The edge where counter goes 1->0 moves to DONE and copies the shift register into data_out.
  - DONE without start -> IDLE.
  - DONE with start -> accepts the new request (back-to-back supported).
- Latency:
  - done=1 in the cycle after edge E_n, where n=shamt (n=0 means the cycle right after E0).
  - busy=1 exactly during SHIFT state cycles.
- start while in SHIFT is ignored and not queued.
- 1-bit step rules:
  - SLL: {r[WIDTH-2:0],0}
  - SRL: {0,r[WIDTH-1:1]}
  - SRA: {r[WIDTH-1],r[WIDTH-1:1]}, so the sign is preserved across all steps
  - ROL: {r[WIDTH-2:0],r[WIDTH-1]}
  - ROR: {r[0],r[WIDTH-1:1]}
- data_out:
  - Changes only on entry to DONE and holds its value through IDLE and subsequent SHIFT cycles.
  - Intermediate values are never visible on data_out.
- done and busy are never high in the same cycle.
- shamt=WIDTH-1 (31) is the maximum; the counter never wraps.

Test Plan:
- Reset released. start, op=000, shamt=4, data_in=0x0000000F -> busy=1 for 4 cycles, then done pulse 1 cycle with data_out=0x000000F0; busy=0 afterwards; data_out holds.
- op=010, shamt=31, data_in=0x80000000 -> done after 31 cycles, data_out=0xFFFFFFFF. Repeat with op=001, data_in=0xF0000000, shamt=28 -> data_out=0x0000000F.
- op=100, shamt=1, data_in=0x00000001 -> data_out=0x80000000. Then op=011, shamt=4, data_in=0x80000001 -> data_out=0x00000018.
- shamt=0, op=000, data_in=0x12345678 -> busy never high, done in the next cycle, data_out=0x12345678. Same result for op=110, shamt=7.
- start asserted again 2 cycles into a shamt=8 SLL with different data_in/op -> ignored; result matches the first request. start asserted in the done cycle -> second op accepted and completes correctly.
- reset pulled low 3 cycles into a shamt=10 SRL -> busy, done and data_out clear immediately and asynchronously; no done pulse. The next start after release completes normally.
